// File: rtl/spi_transaction_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM state encoding,
// default chip-select timing and a helper sizing the shared delay counter.
package spi_transaction_sequencer_pkg;

   localparam int DEF_MAX_BYTES        = 16;
   localparam int DEF_CS_SETUP_CLKS    = 2;
   localparam int DEF_CS_HOLD_CLKS     = 2;
   localparam int DEF_CS_INACTIVE_CLKS = 4;

   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_CS_SETUP = 3'd1,
      SEQ_FETCH    = 3'd2,
      SEQ_SEND     = 3'd3,
      SEQ_WAIT_RX  = 3'd4,
      SEQ_CS_HOLD  = 3'd5,
      SEQ_CS_GAP   = 3'd6
   } seq_state_t;

   // The counter is loaded with (cycles - 1), so it must hold max-1.
   function automatic int delay_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/spi_transaction_sequencer_if.sv
// Request, TX/RX byte and controller-side signals of the transaction sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface spi_transaction_sequencer_if #(
   parameter int LEN_W = 5
);
   logic [LEN_W-1:0] i_Req_Len;
   logic             i_Req_Valid;
   logic             o_Req_Ready;
   logic [7:0]       i_TX_Byte;
   logic             i_TX_Valid;
   logic             o_TX_Ready;
   logic [7:0]       o_RX_Byte;
   logic             o_RX_Valid;
   logic             o_Done;
   logic             o_Busy;
   logic [7:0]       o_Ctl_TX_Byte;
   logic             o_Ctl_TX_DV;
   logic             i_Ctl_TX_Ready;
   logic             i_Ctl_RX_DV;
   logic [7:0]       i_Ctl_RX_Byte;
   logic             o_SPI_CS_n;

   modport slave (
      input  i_Req_Len, i_Req_Valid, i_TX_Byte, i_TX_Valid,
             i_Ctl_TX_Ready, i_Ctl_RX_DV, i_Ctl_RX_Byte,
      output o_Req_Ready, o_TX_Ready, o_RX_Byte, o_RX_Valid, o_Done, o_Busy,
             o_Ctl_TX_Byte, o_Ctl_TX_DV, o_SPI_CS_n
   );

   modport master (
      output i_Req_Len, i_Req_Valid, i_TX_Byte, i_TX_Valid,
             i_Ctl_TX_Ready, i_Ctl_RX_DV, i_Ctl_RX_Byte,
      input  o_Req_Ready, o_TX_Ready, o_RX_Byte, o_RX_Valid, o_Done, o_Busy,
             o_Ctl_TX_Byte, o_Ctl_TX_DV, o_SPI_CS_n
   );
endinterface

// File: rtl/spi_transaction_sequencer_delay_counter.sv
// Loadable down-counter with terminal-count flag; shared by the chip-select
// setup, hold and inactive-gap states of the sequencer.
module spi_transaction_sequencer_delay_counter #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Frames a multi-byte SPI transaction with chip select and timed gaps, feeding
// TX bytes to the byte-level controller and returning each RX byte.
module spi_transaction_sequencer
   import spi_transaction_sequencer_pkg::*;
#(
   parameter int MAX_BYTES        = DEF_MAX_BYTES,
   parameter int CS_SETUP_CLKS    = DEF_CS_SETUP_CLKS,
   parameter int CS_HOLD_CLKS     = DEF_CS_HOLD_CLKS,
   parameter int CS_INACTIVE_CLKS = DEF_CS_INACTIVE_CLKS
) (
   input logic                        i_clk,
   input logic                        i_reset,
   spi_transaction_sequencer_if.slave bus
);

   localparam int LEN_W = $clog2(MAX_BYTES + 1);
   localparam int DLY_W = delay_w(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_INACTIVE_CLKS);

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);
   localparam logic [DLY_W-1:0] SETUP_LD = DLY_W'(CS_SETUP_CLKS - 1);
   localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'(CS_HOLD_CLKS - 1);
   localparam logic [DLY_W-1:0] GAP_LD   = DLY_W'(CS_INACTIVE_CLKS - 1);

   seq_state_t       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [7:0]       ctl_tx_byte_q, ctl_tx_byte_d;
   logic             ctl_tx_dv_q, ctl_tx_dv_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic             done_q, done_d;
   logic             cs_n_q, cs_n_d;

   logic             dly_load;
   logic [DLY_W-1:0] dly_val;
   logic             dly_tc;

   spi_transaction_sequencer_delay_counter #(.W(DLY_W)) u_delay (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (dly_load),
      .i_load_val (dly_val),
      .o_tc       (dly_tc)
   );

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      count_d       = count_q;
      ctl_tx_byte_d = ctl_tx_byte_q;
      ctl_tx_dv_d   = 1'b0;
      rx_byte_d     = rx_byte_q;
      rx_valid_d    = 1'b0;
      done_d        = 1'b0;
      cs_n_d        = cs_n_q;
      dly_load      = 1'b0;
      dly_val       = SETUP_LD;

      case (state_q)
         SEQ_IDLE: begin
            if (bus.i_Req_Valid) begin
               len_d    = (bus.i_Req_Len > MAX_LEN) ? MAX_LEN : bus.i_Req_Len;
               count_d  = '0;
               dly_load = 1'b1;
               // An empty request never touches the bus but still reports done.
               if (bus.i_Req_Len == '0) begin
                  state_d = SEQ_CS_GAP;
                  done_d  = 1'b1;
                  dly_val = GAP_LD;
               end else begin
                  state_d = SEQ_CS_SETUP;
                  cs_n_d  = 1'b0;
                  dly_val = SETUP_LD;
               end
            end
         end
         SEQ_CS_SETUP: begin
            if (dly_tc) state_d = SEQ_FETCH;
         end
         SEQ_FETCH: begin
            if (bus.i_TX_Valid) begin
               ctl_tx_byte_d = bus.i_TX_Byte;
               state_d       = SEQ_SEND;
            end
         end
         SEQ_SEND: begin
            if (bus.i_Ctl_TX_Ready) begin
               ctl_tx_dv_d = 1'b1;
               state_d     = SEQ_WAIT_RX;
            end
         end
         SEQ_WAIT_RX: begin
            // Controller ready is deliberately ignored here; only RX advances.
            if (bus.i_Ctl_RX_DV) begin
               rx_byte_d  = bus.i_Ctl_RX_Byte;
               rx_valid_d = 1'b1;
               count_d    = count_q + LEN_W'(1);
               if (count_d == len_q) begin
                  state_d  = SEQ_CS_HOLD;
                  dly_load = 1'b1;
                  dly_val  = HOLD_LD;
               end else begin
                  state_d = SEQ_FETCH;
               end
            end
         end
         SEQ_CS_HOLD: begin
            if (dly_tc) begin
               cs_n_d   = 1'b1;
               done_d   = 1'b1;
               state_d  = SEQ_CS_GAP;
               dly_load = 1'b1;
               dly_val  = GAP_LD;
            end
         end
         SEQ_CS_GAP: begin
            if (dly_tc) state_d = SEQ_IDLE;
         end
         default: begin
            state_d = SEQ_IDLE;
            cs_n_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= SEQ_IDLE;
         len_q         <= '0;
         count_q       <= '0;
         ctl_tx_byte_q <= '0;
         ctl_tx_dv_q   <= 1'b0;
         rx_byte_q     <= '0;
         rx_valid_q    <= 1'b0;
         done_q        <= 1'b0;
         cs_n_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         count_q       <= count_d;
         ctl_tx_byte_q <= ctl_tx_byte_d;
         ctl_tx_dv_q   <= ctl_tx_dv_d;
         rx_byte_q     <= rx_byte_d;
         rx_valid_q    <= rx_valid_d;
         done_q        <= done_d;
         cs_n_q        <= cs_n_d;
      end
   end

   assign bus.o_Req_Ready   = (state_q == SEQ_IDLE);
   assign bus.o_Busy        = (state_q != SEQ_IDLE);
   assign bus.o_TX_Ready    = (state_q == SEQ_FETCH);
   assign bus.o_Ctl_TX_Byte = ctl_tx_byte_q;
   assign bus.o_Ctl_TX_DV   = ctl_tx_dv_q;
   assign bus.o_RX_Byte     = rx_byte_q;
   assign bus.o_RX_Valid    = rx_valid_q;
   assign bus.o_Done        = done_q;
   assign bus.o_SPI_CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Randomized scoreboard bench for the SPI transaction sequencer with a
// behavioural byte-controller model and chip-select timing monitor.
module tb_spi_transaction_sequencer;
   import spi_transaction_sequencer_pkg::*;

   localparam int MAX_BYTES = 16;
   localparam int LEN_W     = $clog2(MAX_BYTES + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_transaction_sequencer_if #(.LEN_W(LEN_W)) bus ();

   spi_transaction_sequencer #(
      .MAX_BYTES        (MAX_BYTES),
      .CS_SETUP_CLKS    (2),
      .CS_HOLD_CLKS     (2),
      .CS_INACTIVE_CLKS (4)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [7:0] exp_ctl[$];
   logic [7:0] exp_rx[$];
   int         exp_done[$];
   bit         resp_fixed = 1'b0;

   // Peripheral response: fixed 0x3C pattern or inverted loopback.
   function automatic logic [7:0] resp(input logic [7:0] b);
      return resp_fixed ? 8'h3C : ~b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Byte-controller model: latency 2..5 cycles, ready low while busy,
   // occasional spurious RX strobes while chip select is high.
   initial begin : ctl_model
      bit         pend;
      int         dly;
      logic [7:0] pb;
      pend = 1'b0; dly = 0; pb = '0;
      bus.i_Ctl_TX_Ready = 1'b1;
      bus.i_Ctl_RX_DV    = 1'b0;
      bus.i_Ctl_RX_Byte  = '0;
      forever begin
         @(negedge clk);
         bus.i_Ctl_RX_DV = 1'b0;
         if (rst) begin
            pend = 1'b0;
            bus.i_Ctl_TX_Ready = 1'b1;
            continue;
         end
         if (bus.o_Ctl_TX_DV) begin
            pend = 1'b1;
            pb   = bus.o_Ctl_TX_Byte;
            dly  = $urandom_range(2, 5);
            bus.i_Ctl_TX_Ready = 1'b0;
         end else if (pend) begin
            dly--;
            if (dly == 0) begin
               bus.i_Ctl_RX_DV    = 1'b1;
               bus.i_Ctl_RX_Byte  = resp(pb);
               bus.i_Ctl_TX_Ready = 1'b1;
               pend = 1'b0;
            end
         end else begin
            bus.i_Ctl_TX_Ready = ($urandom_range(0, 3) != 0);
            if (bus.o_SPI_CS_n && $urandom_range(0, 7) == 0) begin
               bus.i_Ctl_RX_DV   = 1'b1;
               bus.i_Ctl_RX_Byte = 8'($urandom);
            end
         end
      end
   end

   initial begin : monitor
      logic       prev_cs;
      int         high_run, rx_in_txn, last_rx, gap_k, en;
      bit         skip_fall;
      logic [7:0] eb;
      prev_cs = 1'b1; high_run = 0; rx_in_txn = 0; last_rx = 0; gap_k = 0; skip_fall = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_cs = 1'b1; high_run = 0; rx_in_txn = 0; gap_k = 0; skip_fall = 1'b1;
            continue;
         end
         if (bus.o_Ctl_TX_DV) begin
            if (exp_ctl.size() == 0) chk("ctl_dv_unexpected", 1, 0);
            else begin
               eb = exp_ctl.pop_front();
               chk("ctl_tx_byte", 32'(bus.o_Ctl_TX_Byte), 32'(eb));
            end
            chk("ctl_dv_cs_low", 32'(bus.o_SPI_CS_n), 0);
         end
         if (bus.o_RX_Valid) begin
            if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
            else begin
               eb = exp_rx.pop_front();
               chk("rx_byte", 32'(bus.o_RX_Byte), 32'(eb));
            end
            rx_in_txn++;
            last_rx = cyc;
         end
         if (gap_k > 0) begin
            if (gap_k < 4) begin
               chk("gap_req_ready_low", 32'(bus.o_Req_Ready), 0);
               chk("gap_cs_high", 32'(bus.o_SPI_CS_n), 1);
               gap_k++;
            end else begin
               chk("gap_end_req_ready", 32'(bus.o_Req_Ready), 1);
               gap_k = 0;
            end
         end
         if (bus.o_Done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               en = exp_done.pop_front();
               chk("done_rx_count", 32'(rx_in_txn), 32'(en));
               if (en > 0) begin
                  chk("done_delay_after_rx", 32'(cyc - last_rx), 2);
                  chk("done_cs_was_low", 32'(prev_cs), 0);
               end
            end
            chk("done_cs_high", 32'(bus.o_SPI_CS_n), 1);
            chk("done_req_ready_low", 32'(bus.o_Req_Ready), 0);
            rx_in_txn = 0;
            gap_k = 1;
         end
         if (bus.o_SPI_CS_n) high_run++;
         else begin
            if (prev_cs && !skip_fall) chk("cs_high_gap_min4", 32'(high_run >= 4), 1);
            if (prev_cs) skip_fall = 1'b0;
            high_run = 0;
         end
         prev_cs = bus.o_SPI_CS_n;
      end
   end

   task automatic feed_byte(input logic [7:0] v, input bit stall);
      int t;
      t = 0;
      while (!bus.o_TX_Ready && t < 100) begin
         bus.i_TX_Valid = 1'($urandom_range(0, 1));
         bus.i_TX_Byte  = 8'($urandom);
         @(negedge clk);
         t++;
      end
      chk("tx_ready_timeout", 32'(t >= 100), 0);
      if (stall) begin
         bus.i_TX_Valid = 1'b0;
         repeat (10) @(negedge clk);
         chk("stall_cs_low", 32'(bus.o_SPI_CS_n), 0);
         chk("stall_tx_ready", 32'(bus.o_TX_Ready), 1);
      end
      bus.i_TX_Byte  = v;
      bus.i_TX_Valid = 1'b1;
      @(negedge clk);
      bus.i_TX_Valid = 1'b0;
   endtask

   task automatic issue_req(input int len, input bit keep_valid, input bit fixed,
                            input logic [7:0] base, output logic [7:0] b[$]);
      int n, t;
      logic [7:0] v;
      b = {};
      n = (len > MAX_BYTES) ? MAX_BYTES : len;
      for (int i = 0; i < n; i++) begin
         v = fixed ? base + 8'(i) : 8'($urandom);
         b.push_back(v);
         exp_ctl.push_back(v);
         exp_rx.push_back(resp(v));
      end
      exp_done.push_back(n);
      t = 0;
      while (!bus.o_Req_Ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("req_ready_timeout", 32'(t >= 300), 0);
      bus.i_Req_Len   = LEN_W'(len);
      bus.i_Req_Valid = 1'b1;
      @(negedge clk);
      if (!keep_valid) bus.i_Req_Valid = 1'b0;
      chk("cs_after_accept", 32'(bus.o_SPI_CS_n), 32'(n == 0));
      chk("busy_after_accept", 32'(bus.o_Busy), 1);
      if (n > 0) begin
         chk("setup_tx_ready_c1", 32'(bus.o_TX_Ready), 0);
         @(negedge clk);
         chk("setup_tx_ready_c2", 32'(bus.o_TX_Ready), 0);
         @(negedge clk);
         chk("fetch_after_setup", 32'(bus.o_TX_Ready), 1);
      end
   endtask

   task automatic run_req(input int len, input bit stall, input bit keep_valid,
                          input bit fixed, input logic [7:0] base);
      logic [7:0] b[$];
      int t;
      issue_req(len, keep_valid, fixed, base, b);
      for (int i = 0; i < b.size(); i++) feed_byte(b[i], stall && i == 1);
      t = 0;
      while (!bus.o_Done && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", 32'(t >= 300), 0);
   endtask

   initial begin : watchdog
      #500000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : main
      logic [7:0] b[$];
      int t, dones;
      bus.i_Req_Len   = '0;
      bus.i_Req_Valid = 1'b0;
      bus.i_TX_Byte   = '0;
      bus.i_TX_Valid  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.o_Req_Ready), 1);
      chk("rst_busy", 32'(bus.o_Busy), 0);
      chk("rst_cs_n", 32'(bus.o_SPI_CS_n), 1);
      chk("rst_tx_ready", 32'(bus.o_TX_Ready), 0);
      chk("rst_rx_valid", 32'(bus.o_RX_Valid), 0);
      chk("rst_rx_byte", 32'(bus.o_RX_Byte), 0);
      chk("rst_done", 32'(bus.o_Done), 0);
      chk("rst_ctl_dv", 32'(bus.o_Ctl_TX_DV), 0);
      chk("rst_ctl_byte", 32'(bus.o_Ctl_TX_Byte), 0);
      #1 rst = 1'b0;
      @(negedge clk);

      resp_fixed = 1'b1;
      run_req(1, 1'b0, 1'b0, 1'b1, 8'hA5);
      resp_fixed = 1'b0;
      run_req(3, 1'b0, 1'b0, 1'b1, 8'h01);
      run_req(3, 1'b1, 1'b0, 1'b0, 8'h00);
      run_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
      run_req(20, 1'b0, 1'b0, 1'b0, 8'h00);

      // Reset while waiting for the second RX byte of a three-byte transfer.
      issue_req(3, 1'b0, 1'b0, 8'h00, b);
      feed_byte(b[0], 1'b0);
      feed_byte(b[1], 1'b0);
      t = 0;
      while (!bus.o_Ctl_TX_DV && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("reset_test_dv_timeout", 32'(t >= 100), 0);
      #1 rst = 1'b1;
      exp_ctl.delete();
      exp_rx.delete();
      exp_done.delete();
      #1;
      chk("async_rst_cs_n", 32'(bus.o_SPI_CS_n), 1);
      chk("async_rst_busy", 32'(bus.o_Busy), 0);
      chk("async_rst_req_ready", 32'(bus.o_Req_Ready), 1);
      @(negedge clk);
      #1 rst = 1'b0;
      dones = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.o_Done) dones++;
      end
      chk("no_done_after_reset", 32'(dones), 0);
      run_req(2, 1'b0, 1'b0, 1'b0, 8'h00);

      run_req(2, 1'b0, 1'b1, 1'b0, 8'h00);
      run_req(2, 1'b0, 1'b0, 1'b0, 8'h00);

      for (int k = 0; k < 20; k++) begin
         run_req($urandom_range(0, 20), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 8'h00);
      end

      repeat (20) @(negedge clk);
      chk("exp_ctl_left", 32'(exp_ctl.size()), 0);
      chk("exp_rx_left", 32'(exp_rx.size()), 0);
      chk("exp_done_left", 32'(exp_done.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
